// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - VGA timing plus centred 1-bpp framebuffer scanout
// with VRAM word prefetch and fg/bg/border colouring.
module vga_fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FB_WIDTH   = 512,
  parameter int FB_HEIGHT  = 256,
  parameter int WORD_BITS  = 16,
  parameter int COLOR_BITS = 4,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int ADDR_W     = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [WORD_BITS-1:0]    vram_rdata,
  output logic [ADDR_W-1:0]       vram_raddr,
  output logic                    vram_rden,
  input  logic [3*COLOR_BITS-1:0] fg_color,
  input  logic [3*COLOR_BITS-1:0] bg_color,
  input  logic [3*COLOR_BITS-1:0] border_color,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    frame_start,
  output logic                    vblank
);

  localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HA0     = H_FP + H_SYNC + H_BP;
  localparam int X0      = HA0 + (H_ACTIVE - FB_WIDTH) / 2;
  localparam int Y0      = (V_ACTIVE - FB_HEIGHT) / 2;
  localparam int WPL     = FB_WIDTH / WORD_BITS;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic HPOL  = 1'(H_SYNC_POL);
  localparam logic VPOL  = 1'(V_SYNC_POL);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  int hi, vi, x, y, fx, cx, xbit;
  logic active, in_win_v, in_win, fetch_hit, copy_hit, hs_on, vs_on;
  logic [ADDR_W-1:0] fetch_addr;
  logic [WORD_BITS-1:0] fbuf, disp, disp_sh;
  logic pend;
  logic [3*COLOR_BITS-1:0] pix_color;

  always_comb begin
    hi       = int'(h);
    vi       = int'(v);
    x        = hi - X0;
    y        = vi - Y0;
    active   = (vi < V_ACTIVE) && (hi >= HA0);
    in_win_v = (vi >= Y0) && (vi < Y0 + FB_HEIGHT);
    in_win   = in_win_v && (x >= 0) && (x < FB_WIDTH);
    hs_on    = (hi >= H_FP) && (hi < H_FP + H_SYNC);
    vs_on    = (vi >= V_ACTIVE + V_FP) && (vi < V_ACTIVE + V_FP + V_SYNC);
    // Read is issued 3 pixels ahead of its first column; swap 1 pixel ahead.
    fx        = hi + 3 - X0;
    cx        = hi + 1 - X0;
    fetch_hit = in_win_v && (fx >= 0) && (fx < FB_WIDTH) && (fx % WORD_BITS == 0);
    copy_hit  = in_win_v && (cx >= 0) && (cx < FB_WIDTH) && (cx % WORD_BITS == 0);
    fetch_addr = ADDR_W'(y * WPL + fx / WORD_BITS);
    xbit      = in_win ? (x % WORD_BITS) : 0;
    disp_sh   = disp >> xbit;
    if (!active)
      pix_color = '0;
    else if (in_win)
      pix_color = disp_sh[0] ? fg_color : bg_color;
    else
      pix_color = border_color;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      vram_rden   <= 1'b0;
      vram_raddr  <= '0;
      pend        <= 1'b0;
      fbuf        <= '0;
      disp        <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      h_sync      <= ~HPOL;
      v_sync      <= ~VPOL;
    end else begin
      vram_rden   <= 1'b0;
      frame_start <= 1'b0;
      pend        <= vram_rden;
      if (pend)
        fbuf <= vram_rdata;
      if (clken) begin
        if (hi == H_TOTAL - 1) begin
          h <= '0;
          if (vi == V_TOTAL - 1)
            v <= '0;
          else
            v <= v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
        frame_start           <= (hi == H_TOTAL - 1) && (vi == V_TOTAL - 1);
        h_sync                <= hs_on ? HPOL : ~HPOL;
        v_sync                <= vs_on ? VPOL : ~VPOL;
        vblank                <= (vi >= V_ACTIVE);
        {red, green, blue}    <= pix_color;
        if (fetch_hit) begin
          vram_rden  <= 1'b1;
          vram_raddr <= fetch_addr;
        end
        // At full pixel rate the capture and the swap land on the same edge.
        if (copy_hit)
          disp <= pend ? vram_rdata : fbuf;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - self-checking bench for vga_fb_scanout on a
// reduced raster, with a pixel-position reference model.
module tb_vga_fb_scanout;

  localparam int HA = 40, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 12, VFP = 1, VS = 2, VBP = 1;
  localparam int FBW = 16, FBH = 6, WB = 4, CB = 4, AW = 5;
  localparam int HPOL = 1, VPOL = 0;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int HA0 = HFP + HS + HBP;
  localparam int X0 = HA0 + (HA - FBW) / 2;
  localparam int Y0 = (VA - FBH) / 2;
  localparam int WPL = FBW / WB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clken = 1'b0;
  logic [WB-1:0] vram_rdata = '0;
  logic [AW-1:0] vram_raddr;
  logic vram_rden;
  logic [3*CB-1:0] fg_color = '0, bg_color = '0, border_color = '0;
  logic h_sync, v_sync, frame_start, vblank;
  logic [CB-1:0] red, green, blue;

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .WORD_BITS(WB), .COLOR_BITS(CB),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .vram_rdata(vram_rdata), .vram_raddr(vram_raddr), .vram_rden(vram_rden),
    .fg_color(fg_color), .bg_color(bg_color), .border_color(border_color),
    .h_sync(h_sync), .v_sync(v_sync),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #5 clk = ~clk;

  logic [WB-1:0] mem [32];
  always @(posedge clk) if (vram_rden) vram_rdata <= mem[vram_raddr];

  int n_cmp = 0, n_bad = 0;
  int k = 0;
  int rden_cnt = 0;
  int addr_q[$];
  logic e_rden, e_hs, e_vs, e_vb, e_fs;
  logic [AW-1:0] e_raddr;
  logic [3*CB-1:0] e_rgb;

  typedef struct {
    int div; int h; int v;
    logic [11:0] rgb; logic hs; logic vs; logic vb;
  } vec_t;
  vec_t tv[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Expected outputs after the coming edge, derived from the pixel index alone.
  task automatic step(input logic rst, input logic ce);
    int p, hh, vv, x, y, f;
    logic [WB-1:0] ws;
    reset = rst;
    clken = ce;
    e_rden = 1'b0;
    e_fs = 1'b0;
    if (rst) begin
      k = 0; e_raddr = '0; e_hs = !1'(HPOL); e_vs = !1'(VPOL);
      e_vb = 1'b0; e_rgb = '0;
    end else if (ce) begin
      p = k % FT; hh = p % HT; vv = p / HT; x = hh - X0; y = vv - Y0;
      e_hs = (hh >= HFP && hh < HFP + HS) ? 1'(HPOL) : !1'(HPOL);
      e_vs = (vv >= VA + VFP && vv < VA + VFP + VS) ? 1'(VPOL) : !1'(VPOL);
      e_vb = (vv >= VA);
      if (vv >= VA || hh < HA0) e_rgb = '0;
      else if (y >= 0 && y < FBH && x >= 0 && x < FBW) begin
        ws = mem[AW'(y * WPL + x / WB)] >> (x % WB);
        e_rgb = ws[0] ? fg_color : bg_color;
      end else e_rgb = border_color;
      f = hh + 3 - X0;
      if (y >= 0 && y < FBH && f >= 0 && f < FBW && f % WB == 0) begin
        e_rden = 1'b1;
        e_raddr = AW'(y * WPL + f / WB);
      end
      e_fs = (p == FT - 1);
      k++;
    end
    @(negedge clk);
    check("outputs", 32'({vram_rden, vram_raddr, h_sync, v_sync, vblank, frame_start, red, green, blue}),
          32'({e_rden, e_raddr, e_hs, e_vs, e_vb, e_fs, e_rgb}));
    if (vram_rden) begin
      rden_cnt++;
      addr_q.push_back(int'(vram_raddr));
    end
  endtask

  task automatic load_pattern();
    for (int a = 0; a < 32; a++) mem[a] = '0;
    mem[0] = 4'h1;
    mem[3] = 4'h8;
    fg_color = 12'hFFF; bg_color = 12'h000; border_color = 12'h00F;
  endtask

  initial begin
    int c;
    logic rs, ce;
    tv[0]  = '{1, 21, 3, 12'hFFF, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{2, 22, 3, 12'h000, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{3, 36, 3, 12'hFFF, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{1, 35, 3, 12'h000, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{2, 37, 3, 12'h00F, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{1, 20, 3, 12'h00F, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{3, 21, 2, 12'h00F, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{1, 21, 9, 12'h00F, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{2, 8, 3, 12'h000, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{1, 3, 5, 12'h000, 1'b1, 1'b1, 1'b0};
    tv[10] = '{1, 21, 12, 12'h000, 1'b0, 1'b1, 1'b1};
    tv[11] = '{1, 40, 13, 12'h000, 1'b0, 1'b0, 1'b1};
    tv[12] = '{2, 21, 4, 12'h000, 1'b0, 1'b1, 1'b0};
    tv[13] = '{3, 48, 15, 12'h000, 1'b0, 1'b1, 1'b1};

    load_pattern();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0); step(1'b1, 1'b0);
      c = 0;
      while (k < tv[i].v * HT + tv[i].h + 1) begin
        step(1'b0, (c % tv[i].div) == 0);
        c++;
      end
      check($sformatf("vec%0d_rgb", i), 32'({red, green, blue}), 32'(tv[i].rgb));
      check($sformatf("vec%0d_sync", i), 32'({h_sync, v_sync, vblank}), 32'({tv[i].hs, tv[i].vs, tv[i].vb}));
    end

    // Reset held 3 cycles mid-line with clken high.
    step(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check("rst_state", 32'({vram_rden, h_sync, v_sync, red, green, blue}), 32'({1'b0, 1'b0, 1'b1, 12'h000}));
    end
    step(1'b0, 1'b1);
    check("first_pixel", 32'({h_sync, v_sync, vblank, red, green, blue}), 32'({1'b0, 1'b1, 1'b0, 12'h000}));

    // Reset landing on an in-flight read, then a full clean frame.
    c = 0;
    while (!vram_rden && c < 3 * FT) begin step(1'b0, 1'b1); c++; end
    check("rden_seen", 32'(vram_rden), 32'(1));
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    for (int i = 0; i < FT + 2; i++) step(1'b0, 1'b1);

    // Address sequence for one frame at several clken rates.
    for (int d = 1; d <= 3; d++) begin
      step(1'b1, 1'b0);
      rden_cnt = 0;
      addr_q.delete();
      c = 0;
      while (k < FT && c < 4 * FT) begin step(1'b0, (c % d) == 0); c++; end
      check($sformatf("div%0d_rden_count", d), 32'(rden_cnt), 32'(FBH * WPL));
      for (int i = 0; i < addr_q.size() && i < FBH * WPL; i++)
        check($sformatf("div%0d_addr%0d", d, i), 32'(addr_q[i]), 32'(i));
    end

    // Random contents, colours, clken duty and occasional resets.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 32; a++) mem[a] = WB'($urandom);
      step(1'b1, 1'b0); step(1'b1, 1'b0);
      for (int i = 0; i < 2400; i++) begin
        fg_color = 12'($urandom); bg_color = 12'($urandom); border_color = 12'($urandom);
        case (r)
          0: ce = 1'b1;
          1: ce = (i % 2) == 0;
          2: ce = (i % 3) == 0;
          default: ce = ($urandom % 4) != 0;
        endcase
        rs = ($urandom_range(0, 1999) == 0);
        step(rs, ce);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
Parametrised successor to the fixed 512x256 monochrome VGA scanout. Generates VGA timing from generic porch/sync parameters, centres a FB_WIDTH x FB_HEIGHT 1-bpp framebuffer window in the active area, and fetches words from single-port VRAM with a clken-rate-independent double buffer. Colours come from fg/bg/border input ports. Sync polarity is configurable. Sits between the VRAM read port and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
FB_WIDTH, 512, window width; multiple of WORD_BITS and <= H_ACTIVE
FB_HEIGHT, 256, window height; <= V_ACTIVE
WORD_BITS, 16, pixels per VRAM word
COLOR_BITS, 4, bits per colour channel
H_SYNC_POL, 0, asserted level of h_sync
V_SYNC_POL, 0, asserted level of v_sync
ADDR_W, 13, VRAM address width; >= clog2(FB_WIDTH*FB_HEIGHT/WORD_BITS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clken  in  1  pixel-clock enable; counters advance only when high
vram_rdata  in  WORD_BITS  read data, valid the clk cycle after vram_rden
vram_raddr  out  ADDR_W  read address
vram_rden  out  1  one-clk read strobe
fg_color  in  3*COLOR_BITS  {r,g,b} for set bits
bg_color  in  3*COLOR_BITS  {r,g,b} for clear bits
border_color  in  3*COLOR_BITS  active area outside window
h_sync, v_sync  out  1  sync outputs
red, green, blue  out  COLOR_BITS  colour outputs
frame_start  out  1  one-clk pulse when counters wrap to (0,0)
vblank  out  1  high while v is outside active lines

Behaviour:
- Counters h 0..H_TOTAL-1, v 0..V_TOTAL-1 (totals = sums of parameters). Both advance only on clken. h wraps and increments v. Both wrap together at (H_TOTAL-1, V_TOTAL-1).
- Horizontal layout: FP [0,H_FP), sync [H_FP,H_FP+H_SYNC), BP, then active from HA0=H_FP+H_SYNC+H_BP. Vertical layout: active [0,V_ACTIVE), FP, sync [V_ACTIVE+V_FP,+V_SYNC), BP.
- Window: X0=HA0+(H_ACTIVE-FB_WIDTH)/2, Y0=(V_ACTIVE-FB_HEIGHT)/2. Defaults give X0=224, Y0=112. Window-relative x=h-X0, y=v-Y0.
- All of h_sync, v_sync, rgb and vblank are registered. They update on clken edges and reflect the counter state of the previous pixel. This gives a uniform 1-pixel latency.
- Colour:
  - blanking -> 0.
  - active area outside window -> border_color.
  - inside window -> bit (x mod WORD_BITS) of the display word selects fg_color (1) or bg_color (0). LSB is the leftmost pixel.
- Fetch: for each window line and each word n in 0..FB_WIDTH/WORD_BITS-1:
  - On the clken edge where h==X0+WORD_BITS*n-3, raise vram_rden for exactly one clk cycle, with vram_raddr=y*(FB_WIDTH/WORD_BITS)+n.
  - On the following clk edge, capture vram_rdata into the fetch buffer.
  - On the clken edge where h==X0+WORD_BITS*n-1, copy the fetch buffer into the display word.
  - Result: the display word holds word n throughout columns [WORD_BITS*n, WORD_BITS*n+WORD_BITS).
- vram_rden is 0 at all other times. vram_raddr holds its last value when idle. The fetch order is the same at any clken duty cycle.
- frame_start pulses for one clk on the clken edge where the counters wrap to (0,0).
- Reset (synchronous, takes priority over clken):
  - h=v=0.
  - Buffers = 0.
  - vram_rden=0, vram_raddr=0.
  - rgb=0, frame_start=0, vblank=0.
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL.
  - Reset mid-frame abandons any in-flight read; data returning the next cycle is discarded.
- Colour inputs are sampled every pixel. Changes take effect on the next pixel with no tearing guarantee.

Test Plan:
- Reset: hold reset 3 cycles mid-line with clken=1 -> rden=0, rgb=0, h_sync=v_sync=1; first pixel after release corresponds to h=0, v=0.
- Sync timing, defaults, clken=1 -> h_sync low exactly 96 of every 800 clks, starting 1 clk after h=16; v_sync low for lines 490-491 (1-clk skew); frame_start period 420000 clks.
- Fetch schedule -> first rden at h=221, v=112 with addr 0; 32 strobes per line; last at h=717 with addr 31; line v=367 ends with addr 8191; no rden on v=111 or v=368.
- Pixel mapping: VRAM model returns 0x0001 for addr 0 and 0x8000 for addr 31, fg=0xFFF, bg=0x000, border=0x00F -> output 0xFFF at counter h=225, v=112; 0x000 for columns 1..510; 0xFFF for column 511; 0x00F outside the window; 0 in blanking.
- clken at 1/2 and 1/3 rate -> identical address sequence; each rden exactly 1 clk wide; identical pixel stream per clken.
- Non-default parameters (FB_WIDTH=256, FB_HEIGHT=192, WORD_BITS=8, H_SYNC_POL=1) -> X0=352, Y0=144, 32 reads per line, h_sync active high.
